// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the ALU / load requesters and the register-file write port.
// The slave modport is the arbiter's view of the bus; the master modport is the requesters' view.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) ();
  logic              clear_i;
  logic              alu_req_i;
  logic [ADDR_W-1:0] alu_addr_i;
  logic [DATA_W-1:0] alu_data_i;
  logic              alu_gnt_o;
  logic              mem_req_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [DATA_W-1:0] mem_data_i;
  logic              mem_gnt_o;
  logic              write_o;
  logic [ADDR_W-1:0] write_addr_o;
  logic [DATA_W-1:0] write_data_o;
  logic              init_done_o;

  modport slave (
    input  clear_i,
    input  alu_req_i, alu_addr_i, alu_data_i,
    input  mem_req_i, mem_addr_i, mem_data_i,
    output alu_gnt_o, mem_gnt_o,
    output write_o, write_addr_o, write_data_o, init_done_o
  );

  modport master (
    output clear_i,
    output alu_req_i, alu_addr_i, alu_data_i,
    output mem_req_i, mem_addr_i, mem_data_i,
    input  alu_gnt_o, mem_gnt_o,
    input  write_o, write_addr_o, write_data_o, init_done_o
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port owner: zeroing sweep after reset/clear, then round-robin
// arbitration between ALU and load writebacks with a registered write port.
module regfile_wb_arbiter #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8
) (
  input logic                 clk_i,
  input logic                 reset_i,
  regfile_wb_arbiter_if.slave bus
);

  typedef enum logic {INIT, RUN} state_t;
  typedef enum logic {WIN_ALU, WIN_MEM} winner_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state, state_next;
  winner_t           last, last_next;
  logic [ADDR_W-1:0] cnt, cnt_next;
  logic              alu_gnt, mem_gnt;
  logic              wr, wr_next;
  logic [ADDR_W-1:0] waddr, waddr_next;
  logic [DATA_W-1:0] wdata, wdata_next;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state <= INIT;
      cnt   <= '0;
      last  <= WIN_MEM;
      wr    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      last  <= last_next;
      wr    <= wr_next;
      waddr <= waddr_next;
      wdata <= wdata_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    last_next  = last;
    alu_gnt    = 1'b0;
    mem_gnt    = 1'b0;
    wr_next    = 1'b0;
    waddr_next = waddr;
    wdata_next = wdata;
    unique case (state)
      INIT: begin
        wr_next    = 1'b1;
        waddr_next = cnt;
        wdata_next = '0;
        if (bus.clear_i) begin
          cnt_next = '0;
        end else if (cnt == LAST_IDX) begin
          cnt_next   = '0;
          state_next = RUN;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      RUN: begin
        if (bus.clear_i) begin
          state_next = INIT;
          cnt_next   = '0;
        end else begin
          // On a tie the requester that did not win last time gets the port.
          if (bus.alu_req_i && (!bus.mem_req_i || last == WIN_MEM)) begin
            alu_gnt = 1'b1;
          end else if (bus.mem_req_i) begin
            mem_gnt = 1'b1;
          end
          if (alu_gnt) begin
            wr_next    = 1'b1;
            waddr_next = bus.alu_addr_i;
            wdata_next = bus.alu_data_i;
            last_next  = WIN_ALU;
          end else if (mem_gnt) begin
            wr_next    = 1'b1;
            waddr_next = bus.mem_addr_i;
            wdata_next = bus.mem_data_i;
            last_next  = WIN_MEM;
          end
        end
      end
    endcase
  end

  assign bus.alu_gnt_o    = alu_gnt;
  assign bus.mem_gnt_o    = mem_gnt;
  assign bus.write_o      = wr;
  assign bus.write_addr_o = waddr;
  assign bus.write_data_o = wdata;
  assign bus.init_done_o  = (state == RUN);

endmodule
